// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command controller.
// Opcodes, FSM states and UART config defaults live here.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_REQ,
    CFG_DATA
  } state_t;

  localparam logic [7:0] OP_WR  = 8'hAA;
  localparam logic [7:0] OP_RD  = 8'hBB;
  localparam logic [7:0] OP_CFG = 8'hCC;

  typedef struct packed {
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
  } cfg_t;

  localparam logic       CFG_PAR_EN   = 1'b1;
  localparam logic       CFG_PAR_TYP  = 1'b0;
  localparam logic [5:0] CFG_PRESCALE = 6'd32;

  localparam cfg_t CFG_RST = '{
    par_en:   CFG_PAR_EN,
    par_typ:  CFG_PAR_TYP,
    prescale: CFG_PRESCALE
  };

  function automatic cfg_t cfg_decode(
    input logic [7:0] b
  );
    cfg_t c;
    c.par_en   = b[0];
    c.par_typ  = b[1];
    c.prescale = b[7:2];
    return c;
  endfunction

  function automatic logic prescale_ok(
    input logic [5:0] ps
  );
    return (ps == 6'd8) ||
           (ps == 6'd16) ||
           (ps == 6'd32);
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of UART RX/TX, register-file and config signals.
// master = controller side, slave = UART/regfile side.
interface uart_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_data_valid;
  logic              rx_frame_err;

  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic [DATA_W-1:0] reg_rd_data;
  logic              reg_rd_valid;

  logic [DATA_W-1:0] tx_data;
  logic              tx_data_valid;
  logic              tx_busy;

  logic              par_en;
  logic              par_typ;
  logic [5:0]        prescale;
  logic              cmd_err;

  modport master (
    input  rx_data,
    input  rx_data_valid,
    input  rx_frame_err,
    output reg_wr_en,
    output reg_rd_en,
    output reg_addr,
    output reg_wr_data,
    input  reg_rd_data,
    input  reg_rd_valid,
    output tx_data,
    output tx_data_valid,
    input  tx_busy,
    output par_en,
    output par_typ,
    output prescale,
    output cmd_err
  );

  modport slave (
    output rx_data,
    output rx_data_valid,
    output rx_frame_err,
    input  reg_wr_en,
    input  reg_rd_en,
    input  reg_addr,
    input  reg_wr_data,
    output reg_rd_data,
    output reg_rd_valid,
    input  tx_data,
    input  tx_data_valid,
    output tx_busy,
    input  par_en,
    input  par_typ,
    input  prescale,
    input  cmd_err
  );

endinterface

// File: rtl/uart_timeout_cnt.sv
// Inter-byte idle counter; saturates once the limit is reached.
// clr wins over en so a fresh byte always restarts the window.
module uart_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Byte-level command decoder: register write/read and UART config.
// Read data is returned on the TX request channel.
module uart_cmd_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  uart_cmd_ctrl_if.master  bus
);

  import uart_pkg::*;

  state_t     state;
  cfg_t       cfg;
  cfg_t       cfg_new;
  logic [7:0] rx_b;
  logic       rx_open;
  logic       tmo_en;
  logic       tmo_clr;
  logic       tmo_exp;

  assign rx_b    = bus.rx_data[7:0];
  assign cfg_new = cfg_decode(rx_b);

  // Frame errors only matter while the FSM is listening for bytes.
  assign rx_open = (state == IDLE)    ||
                   (state == WR_ADDR) ||
                   (state == WR_DATA) ||
                   (state == RD_ADDR) ||
                   (state == CFG_DATA);

  assign tmo_en  = (state == WR_ADDR) ||
                   (state == WR_DATA) ||
                   (state == RD_ADDR) ||
                   (state == RD_WAIT) ||
                   (state == CFG_DATA);

  // Every entry into a timed state happens on a byte or from IDLE,
  // so clearing outside timed states covers the state-entry restart.
  assign tmo_clr = bus.rx_data_valid || !tmo_en;

  uart_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_exp)
  );

  assign bus.par_en   = cfg.par_en;
  assign bus.par_typ  = cfg.par_typ;
  assign bus.prescale = cfg.prescale;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cfg               <= CFG_RST;
      bus.reg_wr_en     <= 1'b0;
      bus.reg_rd_en     <= 1'b0;
      bus.reg_addr      <= '0;
      bus.reg_wr_data   <= '0;
      bus.tx_data       <= '0;
      bus.tx_data_valid <= 1'b0;
      bus.cmd_err       <= 1'b0;
    end else begin
      bus.reg_wr_en <= 1'b0;
      bus.reg_rd_en <= 1'b0;
      bus.cmd_err   <= 1'b0;
      if (rx_open && bus.rx_frame_err) begin
        state       <= IDLE;
        bus.cmd_err <= 1'b1;
      end else if (tmo_en && tmo_exp) begin
        state       <= IDLE;
        bus.cmd_err <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.rx_data_valid) begin
              unique case (1'b1)
                (rx_b == OP_WR):  state <= WR_ADDR;
                (rx_b == OP_RD):  state <= RD_ADDR;
                (rx_b == OP_CFG): state <= CFG_DATA;
                default:          bus.cmd_err <= 1'b1;
              endcase
            end
          end
          WR_ADDR: begin
            if (bus.rx_data_valid) begin
              bus.reg_addr <= bus.rx_data[ADDR_W-1:0];
              state        <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (bus.rx_data_valid) begin
              bus.reg_wr_data <= bus.rx_data;
              bus.reg_wr_en   <= 1'b1;
              state           <= IDLE;
            end
          end
          RD_ADDR: begin
            if (bus.rx_data_valid) begin
              bus.reg_addr  <= bus.rx_data[ADDR_W-1:0];
              bus.reg_rd_en <= 1'b1;
              state         <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (bus.reg_rd_valid) begin
              bus.tx_data       <= bus.reg_rd_data;
              bus.tx_data_valid <= 1'b1;
              state             <= TX_REQ;
            end
          end
          TX_REQ: begin
            if (!bus.tx_busy) begin
              bus.tx_data_valid <= 1'b0;
              state             <= IDLE;
            end
          end
          CFG_DATA: begin
            if (bus.rx_data_valid) begin
              state <= IDLE;
              if (prescale_ok(cfg_new.prescale)) begin
                cfg <= cfg_new;
              end else begin
                bus.cmd_err <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: byte-stream vector table
// followed by read/TX, reset and timeout sequences.
module tb_uart_cmd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  uart_cmd_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  uart_cmd_ctrl #(
    .DATA_W      (8),
    .ADDR_W      (4),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic [7:0] rx;
    logic       fe;
    logic       wr;
    logic       rd;
    logic       err;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       pe;
    logic       pt;
    logic [5:0] ps;
  } vec_t;

  vec_t vecs [18];

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic fe);
    @(negedge clk);
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    bus.rx_frame_err  = fe;
    @(negedge clk);
    bus.rx_data_valid = 1'b0;
    bus.rx_frame_err  = 1'b0;
  endtask

  function automatic logic [31:0] obs();
    return {10'd0, bus.reg_wr_en, bus.reg_rd_en, bus.cmd_err,
            bus.reg_addr, bus.reg_wr_data,
            bus.par_en, bus.par_typ, bus.prescale};
  endfunction

  function automatic logic [31:0] want(input vec_t v);
    return {10'd0, v.wr, v.rd, v.err, v.addr, v.wd,
            v.pe, v.pt, v.ps};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   bad;
    logic seen;

    //        rx     fe   wr   rd   er   addr  wd     pe   pt   ps
    vecs[0]  = '{8'hAA,1'b0,1'b0,1'b0,1'b0,4'h0,8'h00,1'b1,1'b0,6'd32};
    vecs[1]  = '{8'h05,1'b0,1'b0,1'b0,1'b0,4'h5,8'h00,1'b1,1'b0,6'd32};
    vecs[2]  = '{8'h3C,1'b0,1'b1,1'b0,1'b0,4'h5,8'h3C,1'b1,1'b0,6'd32};
    vecs[3]  = '{8'hCC,1'b0,1'b0,1'b0,1'b0,4'h5,8'h3C,1'b1,1'b0,6'd32};
    vecs[4]  = '{8'h41,1'b0,1'b0,1'b0,1'b0,4'h5,8'h3C,1'b1,1'b0,6'd16};
    vecs[5]  = '{8'hCC,1'b0,1'b0,1'b0,1'b0,4'h5,8'h3C,1'b1,1'b0,6'd16};
    vecs[6]  = '{8'h1D,1'b0,1'b0,1'b0,1'b1,4'h5,8'h3C,1'b1,1'b0,6'd16};
    vecs[7]  = '{8'h77,1'b0,1'b0,1'b0,1'b1,4'h5,8'h3C,1'b1,1'b0,6'd16};
    vecs[8]  = '{8'hAA,1'b0,1'b0,1'b0,1'b0,4'h5,8'h3C,1'b1,1'b0,6'd16};
    vecs[9]  = '{8'h09,1'b1,1'b0,1'b0,1'b1,4'h5,8'h3C,1'b1,1'b0,6'd16};
    vecs[10] = '{8'h3C,1'b0,1'b0,1'b0,1'b1,4'h5,8'h3C,1'b1,1'b0,6'd16};
    vecs[11] = '{8'hCC,1'b0,1'b0,1'b0,1'b0,4'h5,8'h3C,1'b1,1'b0,6'd16};
    vecs[12] = '{8'h83,1'b0,1'b0,1'b0,1'b0,4'h5,8'h3C,1'b1,1'b1,6'd32};
    vecs[13] = '{8'hAA,1'b0,1'b0,1'b0,1'b0,4'h5,8'h3C,1'b1,1'b1,6'd32};
    vecs[14] = '{8'h1F,1'b0,1'b0,1'b0,1'b0,4'hF,8'h3C,1'b1,1'b1,6'd32};
    vecs[15] = '{8'h00,1'b0,1'b1,1'b0,1'b0,4'hF,8'h00,1'b1,1'b1,6'd32};
    vecs[16] = '{8'hCC,1'b0,1'b0,1'b0,1'b0,4'hF,8'h00,1'b1,1'b1,6'd32};
    vecs[17] = '{8'h22,1'b0,1'b0,1'b0,1'b0,4'hF,8'h00,1'b0,1'b1,6'd8};

    bus.rx_data       = '0;
    bus.rx_data_valid = 1'b0;
    bus.rx_frame_err  = 1'b0;
    bus.reg_rd_data   = '0;
    bus.reg_rd_valid  = 1'b0;
    bus.tx_busy       = 1'b0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state",
          {bus.reg_wr_en, bus.reg_rd_en, bus.tx_data_valid,
           bus.cmd_err, bus.reg_addr, bus.reg_wr_data,
           bus.tx_data},
          {4'b0000, 4'h0, 8'h00, 8'h00});
    check("reset_cfg",
          {bus.par_en, bus.par_typ, bus.prescale},
          {1'b1, 1'b0, 6'd32});
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      send(vecs[i].rx, vecs[i].fe);
      check($sformatf("vec%0d", i), obs(), want(vecs[i]));
    end

    // write strobe lasts exactly one cycle
    send(8'hAA, 1'b0);
    send(8'h05, 1'b0);
    send(8'h3C, 1'b0);
    check("wr_pulse",
          {bus.reg_wr_en, bus.reg_rd_en, bus.cmd_err,
           bus.reg_addr, bus.reg_wr_data},
          {3'b100, 4'h5, 8'h3C});
    @(negedge clk);
    check("wr_pulse_end", bus.reg_wr_en, 1'b0);

    // read with TX held busy; a byte during TX_REQ is dropped
    bus.tx_busy = 1'b1;
    send(8'hBB, 1'b0);
    send(8'h07, 1'b0);
    check("rd_strobe",
          {bus.reg_rd_en, bus.reg_wr_en, bus.reg_addr},
          {2'b10, 4'h7});
    bus.reg_rd_data  = 8'h5A;
    bus.reg_rd_valid = 1'b1;
    @(negedge clk);
    bus.reg_rd_valid = 1'b0;
    bus.reg_rd_data  = 8'h00;
    check("tx_req",
          {bus.tx_data_valid, bus.reg_rd_en, bus.tx_data},
          {2'b10, 8'h5A});
    send(8'hAA, 1'b0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.tx_data_valid || bus.tx_data != 8'h5A) bad++;
      @(negedge clk);
    end
    check("tx_hold", bad, 0);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    check("tx_release", bus.tx_data_valid, 1'b0);
    send(8'h05, 1'b0);
    check("rx_not_buffered",
          {bus.cmd_err, bus.reg_wr_en}, 2'b10);

    // reset in the middle of a write command
    send(8'hAA, 1'b0);
    send(8'h05, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_cmd",
          {bus.reg_addr, bus.reg_wr_data, bus.cmd_err,
           bus.par_en, bus.par_typ, bus.prescale},
          {4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 6'd32});
    send(8'h3C, 1'b0);
    check("rst_no_write",
          {bus.cmd_err, bus.reg_wr_en}, 2'b10);

    // reset while a TX request is pending
    bus.tx_busy = 1'b1;
    send(8'hBB, 1'b0);
    send(8'h03, 1'b0);
    bus.reg_rd_data  = 8'hC3;
    bus.reg_rd_valid = 1'b1;
    @(negedge clk);
    bus.reg_rd_valid = 1'b0;
    check("tx_pend", {bus.tx_data_valid, bus.tx_data},
          {1'b1, 8'hC3});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_tx",
          {bus.tx_data_valid, bus.tx_data, bus.reg_addr},
          {1'b0, 8'h00, 4'h0});
    bus.tx_busy = 1'b0;

    // inter-byte timeout
    send(8'hAA, 1'b0);
    send(8'h05, 1'b0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      seen = bus.cmd_err;
    end
    check("timeout_cycles", n, 1025);
    send(8'h3C, 1'b0);
    check("timeout_idle",
          {bus.cmd_err, bus.reg_wr_en}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
